dds_param_ctrl: RTL



---
 rtl/dds_pkg.sv | 21 ++
 rtl/dds_sat_step.sv | 37 +++
 rtl/dds_param_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared encodings for the DDS parameter controller: edit modes, waveforms
// and key positions within the debounced key pulse vector.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_WAVE = 2'd0,
    MODE_FREQ = 2'd1,
    MODE_STEP = 2'd2,
    MODE_AMP  = 2'd3
  } mode_e;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  localparam int KEY_MODE = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;

endpackage

// File: rtl/dds_sat_step.sv
// Combinational saturating step of the tuning word between FREQ_MIN and
// FREQ_MAX; reports whether the word would actually move.
module dds_sat_step #(
  parameter int unsigned       FW_W     = 32,
  parameter logic [FW_W-1:0]   FREQ_MIN = 1,
  parameter logic [FW_W-1:0]   FREQ_MAX = 32'h4000_0000
) (
  input  logic [FW_W-1:0] freq_word,
  input  logic [FW_W:0]   step,
  input  logic            up,
  output logic [FW_W-1:0] freq_next,
  output logic            changed
);

  // The sum is formed one bit wider so an overflow past FREQ_MAX still clamps.
  function automatic logic [FW_W-1:0] sat_add(input logic [FW_W-1:0] f,
                                              input logic [FW_W:0]   s);
    logic [FW_W:0] sum;
    sum = {1'b0, f} + s;
    if (sum > {1'b0, FREQ_MAX}) return FREQ_MAX;
    return sum[FW_W-1:0];
  endfunction

  function automatic logic [FW_W-1:0] sat_sub(input logic [FW_W-1:0] f,
                                              input logic [FW_W:0]   s);
    logic [FW_W:0] floor_sum;
    floor_sum = {1'b0, FREQ_MIN} + s;
    if ({1'b0, f} < floor_sum) return FREQ_MIN;
    return f - s[FW_W-1:0];
  endfunction

  always_comb begin
    freq_next = up ? sat_add(freq_word, step) : sat_sub(freq_word, step);
    changed   = (freq_next != freq_word);
  end

endmodule

// File: rtl/dds_param_ctrl.sv
// Turns debounced key pulses into registered DDS run-time parameters
// (tuning word, waveform select, attenuation) via a four-state edit mode.
module dds_param_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned     FW_W       = 32,
  parameter logic [FW_W-1:0] FREQ_INIT  = 85899,
  parameter logic [FW_W-1:0] FREQ_MIN   = 1,
  parameter logic [FW_W-1:0] FREQ_MAX   = 32'h4000_0000,
  parameter int unsigned     STEP_BASE  = 86,
  parameter int unsigned     STEP_SHIFT = 2,
  parameter int unsigned     STEP_N     = 8,
  parameter int unsigned     AMP_N      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                key_pulse,
  output logic [1:0]                mode,
  output logic [1:0]                wave_sel,
  output logic [FW_W-1:0]           freq_word,
  output logic [$clog2(STEP_N)-1:0] step_idx,
  output logic [$clog2(AMP_N)-1:0]  amp_shift,
  output logic                      param_update
);

  localparam int unsigned      SI_W    = $clog2(STEP_N);
  localparam int unsigned      AMP_W   = $clog2(AMP_N);
  localparam logic [SI_W-1:0]  SI_MAX  = SI_W'(STEP_N - 1);
  localparam logic [AMP_W-1:0] AMP_MAX = AMP_W'(AMP_N - 1);

  if (FREQ_INIT < FREQ_MIN || FREQ_INIT > FREQ_MAX) begin : g_bad_init
    $error("FREQ_INIT lies outside [FREQ_MIN, FREQ_MAX]");
  end

  mode_e             mode_p1;
  logic [1:0]        wave_p1;
  logic [FW_W-1:0]   freq_p1;
  logic [SI_W-1:0]   step_idx_p1;
  logic [AMP_W-1:0]  amp_p1;
  logic              vld_p1;

  logic [FW_W:0]     step_p0;
  logic [FW_W-1:0]   freq_next_p0;
  logic              freq_chg_p0;
  logic              up_p0;
  logic              adj_p0;

  // Stage p0: decode the pulse and precompute the saturated tuning word
  assign up_p0   = key_pulse[KEY_UP];
  assign adj_p0  = !key_pulse[KEY_MODE] && (key_pulse[KEY_UP] ^ key_pulse[KEY_DOWN]);
  assign step_p0 = (FW_W+1)'(STEP_BASE) << (STEP_SHIFT * step_idx_p1);

  dds_sat_step #(
    .FW_W     (FW_W),
    .FREQ_MIN (FREQ_MIN),
    .FREQ_MAX (FREQ_MAX)
  ) u_sat_step (
    .freq_word (freq_p1),
    .step      (step_p0),
    .up        (up_p0),
    .freq_next (freq_next_p0),
    .changed   (freq_chg_p0)
  );

  // Stage p1: registered parameters and the one-cycle update strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_p1     <= MODE_WAVE;
      wave_p1     <= WAVE_SINE;
      freq_p1     <= FREQ_INIT;
      step_idx_p1 <= '0;
      amp_p1      <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (key_pulse[KEY_MODE]) begin
        mode_p1 <= mode_e'(mode_p1 + 2'd1);
      end else if (adj_p0) begin
        case (mode_p1)
          MODE_WAVE: begin
            wave_p1 <= up_p0 ? wave_p1 + 2'd1 : wave_p1 - 2'd1;
            vld_p1  <= 1'b1;
          end
          MODE_FREQ: begin
            freq_p1 <= freq_next_p0;
            vld_p1  <= freq_chg_p0;
          end
          MODE_STEP: begin
            if (up_p0 && step_idx_p1 != SI_MAX)
              step_idx_p1 <= step_idx_p1 + 1'b1;
            else if (!up_p0 && step_idx_p1 != '0)
              step_idx_p1 <= step_idx_p1 - 1'b1;
          end
          default: begin
            if (up_p0 && amp_p1 != AMP_MAX) begin
              amp_p1 <= amp_p1 + 1'b1;
              vld_p1 <= 1'b1;
            end else if (!up_p0 && amp_p1 != '0) begin
              amp_p1 <= amp_p1 - 1'b1;
              vld_p1 <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign mode         = mode_p1;
  assign wave_sel     = wave_p1;
  assign freq_word    = freq_p1;
  assign step_idx     = step_idx_p1;
  assign amp_shift    = amp_p1;
  assign param_update = vld_p1;

endmodule
